// File: rtl/num_conv_pkg.sv
// Shared encodings for the bit-serial number-format converter: conversion modes,
// FSM states and the per-digit datapath operation.
package num_conv_pkg;

   localparam logic [1:0] MODE_SM2TC = 2'b00;
   localparam logic [1:0] MODE_TC2SM = 2'b01;
   localparam logic [1:0] MODE_OC2TC = 2'b10;
   localparam logic [1:0] MODE_TC2OC = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_PASS,
      OP_NEG,
      OP_INC,
      OP_DEC
   } op_t;

   // Positive words always pass through untouched, whatever the mode.
   function automatic op_t mode_op(input logic [1:0] mode, input logic sign);
      if (!sign) return OP_PASS;
      case (mode)
         MODE_SM2TC, MODE_TC2SM: return OP_NEG;
         MODE_OC2TC:             return OP_INC;
         default:                return OP_DEC;
      endcase
   endfunction

endpackage

// File: rtl/conv_digit.sv
// One D-bit digit of the serial datapath: invert+add, add or subtract a carry/borrow.
// Purely combinational; c_top is the carry/borrow entering the digit's top bit.
module conv_digit
   import num_conv_pkg::*;
#(
   parameter int D = 1
) (
   input  op_t          op,
   input  logic [D-1:0] a,
   input  logic         cin,
   output logic [D-1:0] r,
   output logic         c_top,
   output logic         cout
);

   logic [D:0] ch;

   always_comb begin
      ch    = '0;
      r     = '0;
      ch[0] = cin;
      for (int i = 0; i < D; i++) begin
         case (op)
            OP_NEG: begin
               r[i]    = ~a[i] ^ ch[i];
               ch[i+1] = ~a[i] & ch[i];
            end
            OP_INC: begin
               r[i]    = a[i] ^ ch[i];
               ch[i+1] = a[i] & ch[i];
            end
            OP_DEC: begin
               r[i]    = a[i] ^ ch[i];
               ch[i+1] = ~a[i] & ch[i];
            end
            default: begin
               r[i]    = a[i];
               ch[i+1] = ch[i];
            end
         endcase
      end
   end

   assign c_top = ch[D-1];
   assign cout  = ch[D];

endmodule

// File: rtl/num_format_conv.sv
// Serial SM/1C/2C converter, D bits per clock: result valid N/D edges after accept;
// one word in flight, in_ready low until the result is taken with out_ready.
module num_format_conv
   import num_conv_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_ovf
);

   localparam int DIGITS = N / D;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [N-1:0] NEG_ZERO = {1'b1, {(N-1){1'b0}}};

   state_t        state;
   logic [N-1:0]  sr;
   logic [1:0]    mode_q;
   logic          sign_q;
   logic          carry;
   logic [CW-1:0] cnt;

   op_t           op;
   logic [D-1:0]  dig_r;
   logic [D-1:0]  dig_fix;
   logic [N-1:0]  sr_next;
   logic          c_top;
   logic          cout;
   logic          last;
   logic          ovf_next;

   assign op   = mode_op(mode_q, sign_q);
   assign last = (cnt == CW'(DIGITS - 1));

   conv_digit #(.D(D)) u_digit (
      .op    (op),
      .a     (sr[D-1:0]),
      .cin   (carry),
      .r     (dig_r),
      .c_top (c_top),
      .cout  (cout)
   );

   // In the SM modes the sign bit is set directly; carry into it only flags an all-zero magnitude.
   always_comb begin
      dig_fix = dig_r;
      if (last && op == OP_NEG)
         dig_fix[D-1] = (mode_q == MODE_TC2SM) ? 1'b1 : ~c_top;
   end

   assign ovf_next = last && sign_q && c_top &&
                     (mode_q == MODE_TC2SM || mode_q == MODE_TC2OC);

   if (D == N) begin : g_full
      assign sr_next = dig_fix;
   end else begin : g_part
      assign sr_next = {dig_fix, sr[N-1:D]};
   end

   assign out_data = sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sr        <= '0;
         mode_q    <= '0;
         sign_q    <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  sr       <= in_data;
                  mode_q   <= in_mode;
                  sign_q   <= in_data[N-1];
                  carry    <= 1'b1;
                  cnt      <= '0;
                  out_ovf  <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               carry <= cout;
               cnt   <= cnt + CW'(1);
               // Unrepresentable results echo the input word, which the shifts have already consumed.
               sr    <= ovf_next ? NEG_ZERO : sr_next;
               if (last) begin
                  out_ovf   <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/num_format_conv.md
NUM_FORMAT_CONV -- requirements
Module: num_format_conv

Interface
REQ-001 Parameter N, default 8: word width in bits; N >= 2.
REQ-002 Parameter D, default 1: bits processed per clock; N SHALL be an integer multiple of D.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_mode are valid this cycle.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  N  word to convert.
REQ-008 in_mode  input  2  conversion: 00 SM->2C, 01 2C->SM, 10 1C->2C, 11 2C->1C.
REQ-009 out_valid  output  1  out_data/out_ovf are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  N  converted word.
REQ-012 out_ovf  output  1  result not representable in the target format.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 IDLE: on in_valid, latch in_data, in_mode and sign bit in_data[N-1], clear the digit counter, and go to RUN.
REQ-015 RUN: one D-bit digit per clock, LSB digit first, with carry/borrow held in a 1-bit register between digits; after N/D digits go to DONE.
REQ-016 Latency: out_valid SHALL rise on the N/D-th rising edge after the accepting edge (N=8, D=1: 8 edges; N=8, D=4: 2 edges).
REQ-017 DONE: out_data/out_ovf SHALL hold stable until out_ready is 1, then go to IDLE on that edge; out_ready is ignored outside DONE.
REQ-018 Positive input (sign bit 0) in any mode: out_data = in_data, out_ovf = 0.
REQ-019 Mode 00, negative: out_data = two's complement negation of the magnitude bits with bit N-1 = 1 (serial invert-and-add, initial carry 1); negative zero (1 followed by zeros) SHALL give out_data = 0, out_ovf = 0.
REQ-020 Mode 01, negative: out_data = {1, negation of bits N-2..0}; input 1 followed by zeros SHALL give out_data = in_data, out_ovf = 1.
REQ-021 Mode 10, negative: out_data = in_data + 1 modulo 2^N; all-ones input (1C negative zero) SHALL give 0.
REQ-022 Mode 11, negative: out_data = in_data - 1; input 1 followed by zeros SHALL give out_data = in_data, out_ovf = 1.
REQ-023 Bit N-1 SHALL never pass through the carry chain except in modes 10 and 11.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; the word is taken only when in_ready is 1.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, out_data 0, out_ovf 0, out_valid 0, in_ready 1 (after release).
REQ-026 Reset during RUN or DONE SHALL discard the word in flight with no out_valid pulse.

Structure
REQ-027 Mode encodings and the state encodings SHALL be localparams in a shared include package num_conv_pkg.
REQ-028 The per-digit datapath SHALL be the sub-module conv_digit (D-bit serial invert/add/subtract with carry-in and carry-out), instantiated once.
REQ-029 The implementation SHALL use one shift register of N bits for both operand and result.

Verification
REQ-030 N=8, D=1, mode 00, in_data 0x85 -> out_data 0xFB, out_ovf 0, out_valid 8 edges after acceptance.
REQ-031 Mode 01, 0xFB -> 0x85; mode 01, 0x80 -> 0x80 with out_ovf 1; mode 00, 0x80 -> 0x00.
REQ-032 Mode 10, 0xFA -> 0xFB; mode 10, 0xFF -> 0x00; mode 11, 0xFB -> 0xFA; mode 11, 0x80 -> ovf 1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_data stable, in_ready 0, second in_valid ignored.
REQ-034 rst_n pulsed low in 4th RUN cycle -> outputs 0 at once, no out_valid, next word converts correctly.
REQ-035 N=16, D=4, mode 00, 0x8001 -> 0xFFFF after 4 edges; exhaustive check of all 256 words x 4 modes at N=8.
